operand2_shift_pipe: RTL and testbench



---
 rtl/operand2_shift_pipe_pkg.sv | 32 +++
 rtl/operand2_shift_pipe_core.sv | 122 ++++++++++++
 rtl/operand2_shift_pipe.sv | 110 +++++++++++
 tb/tb_operand2_shift_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/operand2_shift_pipe_pkg.sv
// Shared encodings and field widths for the operand-2 shifter pipeline.
package operand2_shift_pipe_pkg;

  localparam int SHIFT_OPERAND_LEN = 12;
  localparam int IMMEDIATE_LEN     = 8;
  localparam int ROTATE_IMM_LEN    = 4;
  localparam int SHIFT_IMM_LEN     = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_code_e;

  typedef enum logic [1:0] {
    MODE_MEM       = 2'b00,
    MODE_IMM       = 2'b01,
    MODE_SHIFT_IMM = 2'b10,
    MODE_SHIFT_REG = 2'b11
  } op2_mode_e;

  // Memory offset beats immediate, which beats the register-shift bit.
  function automatic op2_mode_e decode_mode(input logic is_mem, input logic is_imm,
                                            input logic reg_shift);
    if (is_mem)         return MODE_MEM;
    else if (is_imm)    return MODE_IMM;
    else if (reg_shift) return MODE_SHIFT_REG;
    else                return MODE_SHIFT_IMM;
  endfunction

endpackage

// File: rtl/operand2_shift_pipe_core.sv
// Combinational barrel shifter: all shift kinds are mapped onto one log2-stage
// right funnel shift of {hi, lo, guard}; LSL runs on the bit-reversed operand.
module barrel_shift_core
  import operand2_shift_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op2_mode_e          mode_i,
  input  shift_code_e        code_i,
  input  logic [7:0]         amount_i,
  input  logic [DATA_W-1:0]  value_i,
  input  logic               carry_i,
  output logic [DATA_W-1:0]  result_o,
  output logic               carry_o
);

  localparam int LW = $clog2(DATA_W);
  localparam int SW = LW + 1;
  localparam int WW = 2 * DATA_W + 1;
  localparam int SHIFT32 = 32;
  localparam logic [7:0] W8 = 8'(DATA_W);

  logic [DATA_W-1:0] value_rev, src, hi, res_raw, res_rev;
  logic [SW-1:0]     sh;
  logic [4:0]        n;
  logic              rev, kill, cin_pass, ror0;
  logic [WW-1:0]     stg [SW+1];

  always_comb begin
    value_rev = '0;
    for (int i = 0; i < DATA_W; i++) value_rev[i] = value_i[DATA_W-1-i];
  end

  always_comb begin
    rev      = 1'b0;
    kill     = 1'b0;
    cin_pass = 1'b0;
    ror0     = 1'b0;
    hi       = '0;
    sh       = '0;
    n        = amount_i[4:0];
    case (mode_i)
      MODE_MEM: cin_pass = 1'b1;
      MODE_IMM: begin
        hi       = value_i;
        sh       = SW'(amount_i);
        cin_pass = (amount_i == 8'd0);
      end
      MODE_SHIFT_IMM: begin
        case (code_i)
          SH_LSL: begin
            rev      = 1'b1;
            sh       = SW'(n);
            cin_pass = (n == 5'd0);
          end
          SH_LSR: sh = (n == 5'd0) ? SW'(SHIFT32) : SW'(n);
          SH_ASR: begin
            hi = {DATA_W{value_i[DATA_W-1]}};
            sh = (n == 5'd0) ? SW'(SHIFT32) : SW'(n);
          end
          SH_ROR: begin
            // ROR #0 is RRX: a rotate by one whose incoming bit is carry_in.
            if (n == 5'd0) begin
              hi = {value_i[DATA_W-1:1], carry_i};
              sh = SW'(1);
            end else begin
              hi = value_i;
              sh = SW'(n);
            end
          end
        endcase
      end
      MODE_SHIFT_REG: begin
        if (amount_i == 8'd0) begin
          cin_pass = 1'b1;
        end else begin
          case (code_i)
            SH_LSL: begin
              rev = 1'b1;
              if (amount_i > W8) kill = 1'b1;
              else               sh = SW'(amount_i);
            end
            SH_LSR: begin
              if (amount_i > W8) kill = 1'b1;
              else               sh = SW'(amount_i);
            end
            SH_ASR: begin
              hi = {DATA_W{value_i[DATA_W-1]}};
              sh = (amount_i >= W8) ? SW'(DATA_W) : SW'(amount_i);
            end
            SH_ROR: begin
              hi   = value_i;
              sh   = SW'(amount_i[LW-1:0]);
              ror0 = (amount_i[LW-1:0] == '0);
            end
          endcase
        end
      end
    endcase
  end

  assign src    = rev ? value_rev : value_i;
  assign stg[0] = {hi, src, 1'b0};

  for (genvar k = 0; k < SW; k++) begin : g_stage
    assign stg[k+1] = sh[k] ? (stg[k] >> (1 << k)) : stg[k];
  end

  // Guard bit at [0] collects the last bit shifted out.
  assign res_raw = stg[SW][DATA_W:1];

  always_comb begin
    res_rev = '0;
    for (int i = 0; i < DATA_W; i++) res_rev[i] = res_raw[DATA_W-1-i];
  end

  assign result_o = kill ? '0 : (rev ? res_rev : res_raw);
  assign carry_o  = kill     ? 1'b0 :
                    cin_pass ? carry_i :
                    ror0     ? value_i[DATA_W-1] : stg[SW][0];

endmodule

// File: rtl/operand2_shift_pipe.sv
// Two-stage operand-2 pipeline: stage A latches decoded operands, stage B
// latches the shifter result. Valid/ready on both sides, sync flush.
module operand2_shift_pipe
  import operand2_shift_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             val_r_m,
  input  logic [DATA_W-1:0]             val_r_s,
  input  logic [SHIFT_OPERAND_LEN-1:0]  shift_operand,
  input  logic                          imm,
  input  logic                          is_mem_related,
  input  logic                          carry_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             val_2,
  output logic                          shifter_carry_out
);

  op2_mode_e         a_mode_d, a_mode_q;
  shift_code_e       a_code_d, a_code_q;
  logic [7:0]        a_amt_d, a_amt_q;
  logic [DATA_W-1:0] a_val_d, a_val_q;
  logic              a_cin_q, a_valid_q;
  logic              b_valid_q, b_carry_q;
  logic [DATA_W-1:0] b_val_q;
  logic              a_adv;
  logic [DATA_W-1:0] core_res;
  logic              core_carry;
  logic              unused_rs;

  assign unused_rs = ^val_r_s[DATA_W-1:8];

  always_comb begin
    a_mode_d = decode_mode(is_mem_related, imm, shift_operand[4]);
    a_code_d = shift_code_e'(shift_operand[6:5]);
    a_val_d  = val_r_m;
    a_amt_d  = '0;
    case (a_mode_d)
      MODE_MEM:       a_val_d = DATA_W'(shift_operand);
      MODE_IMM: begin
        a_val_d = DATA_W'(shift_operand[IMMEDIATE_LEN-1:0]);
        a_amt_d = {3'b000, shift_operand[11:8], 1'b0};
      end
      MODE_SHIFT_IMM: a_amt_d = {3'b000, shift_operand[11:7]};
      MODE_SHIFT_REG: a_amt_d = val_r_s[7:0];
    endcase
  end

  assign a_adv    = !b_valid_q || out_ready;
  assign in_ready = !a_valid_q || a_adv;

  barrel_shift_core #(.DATA_W(DATA_W)) u_core (
    .mode_i   (a_mode_q),
    .code_i   (a_code_q),
    .amount_i (a_amt_q),
    .value_i  (a_val_q),
    .carry_i  (a_cin_q),
    .result_o (core_res),
    .carry_o  (core_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_mode_q  <= MODE_MEM;
      a_code_q  <= SH_LSL;
      a_amt_q   <= '0;
      a_val_q   <= '0;
      a_cin_q   <= 1'b0;
      b_valid_q <= 1'b0;
      b_val_q   <= '0;
      b_carry_q <= 1'b0;
    end else if (flush) begin
      // Drop everything in flight, including a request handshaking this cycle.
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      b_val_q   <= '0;
      b_carry_q <= 1'b0;
    end else begin
      if (in_ready) begin
        a_valid_q <= in_valid;
        if (in_valid) begin
          a_mode_q <= a_mode_d;
          a_code_q <= a_code_d;
          a_amt_q  <= a_amt_d;
          a_val_q  <= a_val_d;
          a_cin_q  <= carry_in;
        end
      end
      if (a_adv) begin
        b_valid_q <= a_valid_q;
        if (a_valid_q) begin
          b_val_q   <= core_res;
          b_carry_q <= core_carry;
        end
      end
    end
  end

  assign out_valid         = b_valid_q;
  assign val_2             = b_val_q;
  assign shifter_carry_out = b_carry_q;

endmodule

// File: tb/tb_operand2_shift_pipe.sv
// Scoreboard bench: stimulus pushes hand-computed results, a monitor pops on
// every output handshake and compares.
module tb_operand2_shift_pipe;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] val_r_m, val_r_s, val_2;
  logic [11:0] shift_operand;
  logic        imm, is_mem_related, carry_in, shifter_carry_out;

  typedef struct packed {
    logic [31:0] v;
    logic        c;
  } exp_t;

  typedef struct packed {
    logic [11:0] so;
    logic        im;
    logic        mem;
    logic [31:0] rm;
    logic [31:0] rs;
    logic        cin;
    logic [31:0] ev;
    logic        ec;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[20];
  int          nvec;
  int          errors = 0;
  int          checks = 0;
  logic        stall_q = 1'b0;
  logic [32:0] held_v;

  operand2_shift_pipe #(.DATA_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .val_r_m           (val_r_m),
    .val_r_s           (val_r_s),
    .shift_operand     (shift_operand),
    .imm               (imm),
    .is_mem_related    (is_mem_related),
    .carry_in          (carry_in),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .val_2             (val_2),
    .shifter_carry_out (shifter_carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (stall_q && !rst) chk("stall_hold", {31'b0, out_valid, shifter_carry_out, val_2},
                             {31'b0, 1'b1, held_v});
    stall_q = out_valid && !out_ready && !flush && !rst;
    held_v  = {shifter_carry_out, val_2};
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", val_2);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("val_2", {32'b0, val_2}, {32'b0, e.v});
        chk("carry", {63'b0, shifter_carry_out}, {63'b0, e.c});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input vec_t t);
    bit acc = 0;
    shift_operand  = t.so;
    imm            = t.im;
    is_mem_related = t.mem;
    val_r_m        = t.rm;
    val_r_s        = t.rs;
    carry_in       = t.cin;
    in_valid       = 1'b1;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{v: t.ev, c: t.ec});
        acc = 1;
        break;
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && q.size() != 0; w++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic vec_t mk(input logic [11:0] so, input logic im, input logic mem,
                              input logic [31:0] rm, input logic [31:0] rs, input logic cin,
                              input logic [31:0] ev, input logic ec);
    return '{so: so, im: im, mem: mem, rm: rm, rs: rs, cin: cin, ev: ev, ec: ec};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    val_r_m = '0; val_r_s = '0; shift_operand = '0;
    imm = 1'b0; is_mem_related = 1'b0; carry_in = 1'b0;

    nvec = 0;
    vecs[nvec++] = mk(12'h0FF, 1, 0, 32'h0,        32'h0,   0, 32'h000000FF, 0);
    vecs[nvec++] = mk(12'h020, 0, 0, 32'h80000001, 32'h0,   0, 32'h00000000, 1);
    vecs[nvec++] = mk(12'h040, 0, 0, 32'h80000001, 32'h0,   0, 32'hFFFFFFFF, 1);
    vecs[nvec++] = mk(12'h060, 0, 0, 32'h00000003, 32'h0,   1, 32'h80000001, 1);
    vecs[nvec++] = mk(12'h010, 0, 0, 32'hFFFFFFFF, 32'h20,  0, 32'h00000000, 1);
    vecs[nvec++] = mk(12'h010, 0, 0, 32'hFFFFFFFF, 32'h21,  1, 32'h00000000, 0);
    vecs[nvec++] = mk(12'h010, 0, 0, 32'hFFFFFFFF, 32'h100, 1, 32'hFFFFFFFF, 1);
    vecs[nvec++] = mk(12'hABC, 1, 1, 32'h12345678, 32'h0,   1, 32'h00000ABC, 1);
    vecs[nvec++] = mk(12'h200, 0, 0, 32'hF000000F, 32'h0,   0, 32'h000000F0, 1);
    vecs[nvec++] = mk(12'h0A0, 0, 0, 32'h00000003, 32'h0,   0, 32'h00000001, 1);
    vecs[nvec++] = mk(12'h240, 0, 0, 32'h80000018, 32'h0,   0, 32'hF8000001, 1);
    vecs[nvec++] = mk(12'h460, 0, 0, 32'h12345678, 32'h0,   1, 32'h78123456, 0);
    vecs[nvec++] = mk(12'h030, 0, 0, 32'h80000000, 32'h20,  0, 32'h00000000, 1);
    vecs[nvec++] = mk(12'h030, 0, 0, 32'h000000F8, 32'h04,  0, 32'h0000000F, 1);
    vecs[nvec++] = mk(12'h050, 0, 0, 32'h80000000, 32'h40,  0, 32'hFFFFFFFF, 1);
    vecs[nvec++] = mk(12'h070, 0, 0, 32'h80000001, 32'h20,  0, 32'h80000001, 1);
    vecs[nvec++] = mk(12'h070, 0, 0, 32'h0000000F, 32'h24,  0, 32'hF0000000, 1);
    vecs[nvec++] = mk(12'h010, 0, 0, 32'h1000000F, 32'h04,  0, 32'h000000F0, 1);

    tick();
    chk("in_reset_out_valid", {63'b0, out_valid}, 64'd0);
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_val_2", {32'b0, val_2}, 64'd0);
    chk("rst_carry", {63'b0, shifter_carry_out}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Latency on the first rotated immediate.
    send(mk(12'h4FF, 1, 0, 32'h0, 32'h0, 1, 32'hFF000000, 1));
    @(negedge clk);
    chk("lat_cycle1", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_cycle2", {63'b0, out_valid}, 64'd1);
    tick();

    for (int i = 0; i < nvec; i++) send(vecs[i]);
    drain();

    // Backpressure: four requests, consumer stalled for three cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++)
          send(mk(12'(i * 17), 0, 1, 32'h0, 32'h0, i[0], 32'(i * 17), i[0]));
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
        tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with an empty pipe drops the request handshaking that cycle.
    shift_operand = 12'h123; is_mem_related = 1'b1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_drop", {63'b0, out_valid}, 64'd0);
    end
    tick();

    // Flush with both stages full and stalled.
    out_ready = 1'b0;
    send(mk(12'h111, 0, 1, 32'h0, 32'h0, 0, 32'h111, 0));
    send(mk(12'h222, 0, 1, 32'h0, 32'h0, 1, 32'h222, 1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    send(mk(12'h000, 0, 0, 32'hCAFEF00D, 32'h0, 1, 32'hCAFEF00D, 1));
    @(negedge clk);
    chk("flush_lat1", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    chk("flush_lat2", {63'b0, out_valid}, 64'd1);
    tick();
    drain();

    // Reset mid-stream.
    out_ready = 1'b0;
    send(mk(12'h4FF, 1, 0, 32'h0, 32'h0, 0, 32'hFF000000, 1));
    send(mk(12'h060, 0, 0, 32'h00000003, 32'h0, 1, 32'h80000001, 1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_val_2", {32'b0, val_2}, 64'd0);
    chk("mid_rst_carry", {63'b0, shifter_carry_out}, 64'd0);
    chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    send(mk(12'h0A0, 0, 0, 32'h00000003, 32'h0, 0, 32'h00000001, 1));
    drain();

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
